cpu_sfr_bridge: RTL and testbench

- Sits between the CPU execute stage and the port I/O register block, directly upstream of it.
- Converts CPU SFR requests (byte read, byte write, bit write) into single-cycle MEM_RD/MEM_WR strobes on the SFR memory bus.
- Bit writes (SETB/CLR/MOV bit on P0..P3) are performed as read-modify-write sequences, so the CPU never drives partial bytes onto the bus.

---
 rtl/cpu_sfr_bridge.sv | 264 ++++++++++++++++++++++++++
 tb/tb_cpu_sfr_bridge.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sfr_bridge.sv
// ---------------------------------------------------------------------------
// cpu_sfr_bridge
//
// Purpose:
//   Bridges CPU execute-stage SFR requests onto the single-cycle SFR memory
//   bus that feeds the port I/O register block. The bridge supports three
//   request types:
//     - byte writes, issued as one MEM_WR strobe;
//     - byte reads, issued as one MEM_RD strobe followed by a data capture;
//     - bit writes to P0..P3, performed as read-modify-write sequences so
//       that the bus only ever carries whole bytes.
//   Only one request is in flight at a time. A response pulse marks the end
//   of every accepted request.
//
// Ports:
//   CLK          clock
//   RST          synchronous active-high reset
//   REQ_VALID    request present
//   REQ_READY    bridge can accept a request (IDLE and not in reset)
//   REQ_OP       00 byte write, 01 byte read, 10 bit write, 11 reserved
//   REQ_ADDR     byte address (ops 00/01) or bit address (op 10)
//   REQ_WDATA    byte write data
//   REQ_BIT_VAL  bit value for a bit write
//   RSP_VALID    one-cycle completion pulse
//   RSP_ERR      qualifies RSP_VALID: the request was rejected
//   RSP_DATA     read byte (op 01) or written-back byte (op 10), else 0
//   MEM_ADDR     SFR bus address
//   MEM_WR_DATA  SFR bus write data
//   MEM_WR       SFR bus write strobe
//   MEM_RD       SFR bus read strobe
//   MEM_RD_DATA  SFR bus read data, valid the cycle after MEM_RD
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module cpu_sfr_bridge #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [1:0]        REQ_OP,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    input  logic              REQ_BIT_VAL,
    output logic              RSP_VALID,
    output logic              RSP_ERR,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WR_DATA,
    output logic              MEM_WR,
    output logic              MEM_RD,
    input  logic [DATA_W-1:0] MEM_RD_DATA
);

    // -----------------------------------------------------------------------
    // Request encodings and controller states
    // -----------------------------------------------------------------------
    localparam logic [1:0] OP_BYTE_WR = 2'b00;
    localparam logic [1:0] OP_BYTE_RD = 2'b01;
    localparam logic [1:0] OP_BIT_WR  = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;

    // The state names the bus phase currently being presented; every
    // registered output is computed one cycle ahead, when entering a state.
    typedef enum logic [2:0] {
        IDLE = 3'd0,  // waiting for a request
        RD   = 3'd1,  // MEM_RD strobe on the bus
        CAP  = 3'd2,  // MEM_RD_DATA valid, captured this cycle
        WR   = 3'd3,  // MEM_WR strobe on the bus
        RSP  = 3'd4   // RSP_VALID pulse
    } state_e;

    // -----------------------------------------------------------------------
    // State and captured request fields
    // -----------------------------------------------------------------------
    state_e            state_q,       state_d;
    logic [1:0]        op_q,          op_d;
    logic [2:0]        bit_idx_q,     bit_idx_d;
    logic              bit_val_q,     bit_val_d;

    // Registered outputs
    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
    logic              mem_wr_q,      mem_wr_d;
    logic              mem_rd_q,      mem_rd_d;
    logic              rsp_valid_q,   rsp_valid_d;
    logic              rsp_err_q,     rsp_err_d;
    logic [DATA_W-1:0] rsp_data_q,    rsp_data_d;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic              req_ready;
    logic              accept;
    logic              req_err;
    logic [ADDR_W-1:0] bit_byte_addr;
    logic [DATA_W-1:0] merged_byte;

    // Ready is the only combinational output: it must drop in the same
    // cycle RST is raised, before any flop has seen the reset.
    assign req_ready = (state_q == IDLE) && !RST;
    assign accept    = REQ_VALID && req_ready;

    // Bit addresses below the top half map to bit-addressable RAM, which is
    // served elsewhere; only SFR bits (P0..P3 etc.) are handled here.
    assign req_err = (REQ_OP == OP_RSVD) ||
                     ((REQ_OP == OP_BIT_WR) && !REQ_ADDR[ADDR_W-1]);

    // A bit address selects bit [2:0] of the byte at the 8-aligned address.
    assign bit_byte_addr = {REQ_ADDR[ADDR_W-1:3], 3'b000};

    // Read-modify-write merge: the freshly read byte with one bit replaced.
    // NOTE: every variable driven in an always_comb gets a value before any
    // conditional logic, so no path can leave it unassigned and infer a latch.
    always_comb begin
        merged_byte            = MEM_RD_DATA;
        merged_byte[bit_idx_q] = bit_val_q;
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // Hold state and captured fields; strobes and response default low
        // so that each is a single-cycle pulse. MEM_ADDR and MEM_WR_DATA
        // hold their last value, keeping the bus stable between accesses.
        state_d       = state_q;
        op_d          = op_q;
        bit_idx_d     = bit_idx_q;
        bit_val_d     = bit_val_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_wr_d      = 1'b0;
        mem_rd_d      = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_data_d    = '0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = REQ_OP;
                    bit_idx_d = REQ_ADDR[2:0];
                    bit_val_d = REQ_BIT_VAL;

                    if (req_err) begin
                        // Rejected without touching the bus.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        state_d     = RSP;
                    end else begin
                        unique case (REQ_OP)
                            OP_BYTE_WR: begin
                                mem_wr_d      = 1'b1;
                                mem_addr_d    = REQ_ADDR;
                                mem_wr_data_d = REQ_WDATA;
                                state_d       = WR;
                            end
                            OP_BYTE_RD: begin
                                mem_rd_d   = 1'b1;
                                mem_addr_d = REQ_ADDR;
                                state_d    = RD;
                            end
                            OP_BIT_WR: begin
                                mem_rd_d   = 1'b1;
                                mem_addr_d = bit_byte_addr;
                                state_d    = RD;
                            end
                            default: begin
                                // Reserved op is always flagged by req_err.
                                state_d = IDLE;
                            end
                        endcase
                    end
                end
            end

            RD: begin
                // Read data arrives one cycle after the strobe.
                state_d = CAP;
            end

            CAP: begin
                if (op_q == OP_BIT_WR) begin
                    // Write back unconditionally, even if the bit already
                    // held the requested value.
                    mem_wr_d      = 1'b1;
                    mem_wr_data_d = merged_byte;
                    state_d       = WR;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = MEM_RD_DATA;
                    state_d     = RSP;
                end
            end

            WR: begin
                rsp_valid_d = 1'b1;
                // A bit write reports the byte it wrote back; a plain byte
                // write reports zero.
                rsp_data_d  = (op_q == OP_BIT_WR) ? mem_wr_data_q : '0;
                state_d     = RSP;
            end

            RSP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // Reset clears every flop, so an aborted request leaves no strobe or
    // response behind and the bus returns to all-zero.
    // NOTE: sequential state is written with non-blocking assignments so all
    // flops sample their _d values from the same pre-edge snapshot.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            op_q          <= OP_BYTE_WR;
            bit_idx_q     <= '0;
            bit_val_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_wr_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            bit_idx_q     <= bit_idx_d;
            bit_val_q     <= bit_val_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_wr_q      <= mem_wr_d;
            mem_rd_q      <= mem_rd_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign REQ_READY   = req_ready;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_ERR     = rsp_err_q;
    assign RSP_DATA    = rsp_data_q;
    assign MEM_ADDR    = mem_addr_q;
    assign MEM_WR_DATA = mem_wr_data_q;
    assign MEM_WR      = mem_wr_q;
    assign MEM_RD      = mem_rd_q;

endmodule

// File: tb/tb_cpu_sfr_bridge.sv
// ---------------------------------------------------------------------------
// tb_cpu_sfr_bridge
//
// Directed testbench for cpu_sfr_bridge. A small SFR bus model stores
// writes and returns read data one cycle after MEM_RD (zero otherwise).
// Each scenario task drives its own stimulus and compares outputs against
// hand-computed values, sampling 1 ns after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cpu_sfr_bridge;

    logic       CLK;
    logic       RST;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [1:0] REQ_OP;
    logic [7:0] REQ_ADDR;
    logic [7:0] REQ_WDATA;
    logic       REQ_BIT_VAL;
    logic       RSP_VALID;
    logic       RSP_ERR;
    logic [7:0] RSP_DATA;
    logic [7:0] MEM_ADDR;
    logic [7:0] MEM_WR_DATA;
    logic       MEM_WR;
    logic       MEM_RD;
    logic [7:0] MEM_RD_DATA;

    int checks;
    int errors;

    cpu_sfr_bridge #(.DATA_W(8), .ADDR_W(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_OP     (REQ_OP),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_WDATA  (REQ_WDATA),
        .REQ_BIT_VAL(REQ_BIT_VAL),
        .RSP_VALID  (RSP_VALID),
        .RSP_ERR    (RSP_ERR),
        .RSP_DATA   (RSP_DATA),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WR_DATA(MEM_WR_DATA),
        .MEM_WR     (MEM_WR),
        .MEM_RD     (MEM_RD),
        .MEM_RD_DATA(MEM_RD_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SFR bus model: read data valid only in the cycle after MEM_RD.
    logic [7:0] sfr_mem [256];
    always @(posedge CLK) begin
        if (MEM_WR) sfr_mem[MEM_ADDR] <= MEM_WR_DATA;
        MEM_RD_DATA <= MEM_RD ? sfr_mem[MEM_ADDR] : 8'h00;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [7:0] addr,
                             input logic [7:0] wdata, input logic bit_val);
        REQ_OP      = op;
        REQ_ADDR    = addr;
        REQ_WDATA   = wdata;
        REQ_BIT_VAL = bit_val;
        REQ_VALID   = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        checks++;
        if ({RSP_VALID, RSP_ERR, RSP_DATA, MEM_ADDR, MEM_WR_DATA, MEM_WR, MEM_RD} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rv=%b re=%b rd=%h ma=%h wd=%h wr=%b rdst=%b, expected all 0",
                     RSP_VALID, RSP_ERR, RSP_DATA, MEM_ADDR, MEM_WR_DATA, MEM_WR, MEM_RD);
        end
        checks++;
        if (REQ_READY !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: got %b expected 0", REQ_READY);
        end
        RST = 1'b0;
        #1;
        checks++;
        if (REQ_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_release: got %b expected 1", REQ_READY);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_byte_write();
        drive_req(2'b00, 8'h90, 8'hA5, 1'b0);
        tick();  // cycle 1
        REQ_VALID = 1'b0;
        checks++;
        if ({MEM_WR, MEM_RD, MEM_ADDR, MEM_WR_DATA} !== {1'b1, 1'b0, 8'h90, 8'hA5}) begin
            errors++;
            $display("FAIL bw_c1_bus: got wr=%b rd=%b addr=%h data=%h expected wr=1 rd=0 addr=90 data=a5",
                     MEM_WR, MEM_RD, MEM_ADDR, MEM_WR_DATA);
        end
        checks++;
        if ({REQ_READY, RSP_VALID} !== 2'b00) begin
            errors++;
            $display("FAIL bw_c1_ctrl: got ready=%b rv=%b expected 0 0", REQ_READY, RSP_VALID);
        end
        tick();  // cycle 2
        checks++;
        if ({RSP_VALID, RSP_ERR, RSP_DATA, MEM_WR, MEM_RD} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL bw_c2_rsp: got rv=%b re=%b rd=%h wr=%b rdst=%b expected 1 0 00 0 0",
                     RSP_VALID, RSP_ERR, RSP_DATA, MEM_WR, MEM_RD);
        end
        tick();  // cycle 3
        checks++;
        if ({REQ_READY, RSP_VALID, MEM_ADDR, MEM_WR_DATA} !== {1'b1, 1'b0, 8'h90, 8'hA5}) begin
            errors++;
            $display("FAIL bw_c3_idle: got ready=%b rv=%b addr=%h data=%h expected 1 0 90 a5 (bus holds)",
                     REQ_READY, RSP_VALID, MEM_ADDR, MEM_WR_DATA);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_byte_read();
        drive_req(2'b01, 8'h90, 8'h00, 1'b0);
        tick();  // cycle 1
        // Scramble inputs: captured fields must not follow them.
        drive_req(2'b00, 8'h55, 8'h33, 1'b1);
        REQ_VALID = 1'b0;
        checks++;
        if ({MEM_RD, MEM_WR, MEM_ADDR} !== {1'b1, 1'b0, 8'h90}) begin
            errors++;
            $display("FAIL br_c1_bus: got rd=%b wr=%b addr=%h expected 1 0 90", MEM_RD, MEM_WR, MEM_ADDR);
        end
        tick();  // cycle 2
        checks++;
        if ({MEM_RD, MEM_WR, RSP_VALID} !== 3'b000) begin
            errors++;
            $display("FAIL br_c2_quiet: got rd=%b wr=%b rv=%b expected 0 0 0", MEM_RD, MEM_WR, RSP_VALID);
        end
        tick();  // cycle 3
        checks++;
        if ({RSP_VALID, RSP_ERR, RSP_DATA} !== {1'b1, 1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL br_c3_rsp: got rv=%b re=%b data=%h expected 1 0 a5", RSP_VALID, RSP_ERR, RSP_DATA);
        end
        tick();  // cycle 4
        checks++;
        if ({REQ_READY, RSP_VALID, RSP_DATA} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL br_c4_idle: got ready=%b rv=%b data=%h expected 1 0 00", REQ_READY, RSP_VALID, RSP_DATA);
        end
    endtask

    // -----------------------------------------------------------------------
    // One bit write with full cycle-by-cycle checks.
    task automatic run_bit_write(input string name, input logic [7:0] addr, input logic val,
                                 input logic [7:0] exp_byte_addr, input logic [7:0] exp_data);
        drive_req(2'b10, addr, 8'h00, val);
        tick();  // cycle 1
        REQ_VALID = 1'b0;
        checks++;
        if ({MEM_RD, MEM_WR, MEM_ADDR} !== {1'b1, 1'b0, exp_byte_addr}) begin
            errors++;
            $display("FAIL %s_c1_rd: got rd=%b wr=%b addr=%h expected 1 0 %h", name, MEM_RD, MEM_WR, MEM_ADDR, exp_byte_addr);
        end
        tick();  // cycle 2
        checks++;
        if ({MEM_RD, MEM_WR, RSP_VALID} !== 3'b000) begin
            errors++;
            $display("FAIL %s_c2_quiet: got rd=%b wr=%b rv=%b expected 0 0 0", name, MEM_RD, MEM_WR, RSP_VALID);
        end
        tick();  // cycle 3
        checks++;
        if ({MEM_WR, MEM_RD, MEM_ADDR, MEM_WR_DATA} !== {1'b1, 1'b0, exp_byte_addr, exp_data}) begin
            errors++;
            $display("FAIL %s_c3_wr: got wr=%b rd=%b addr=%h data=%h expected 1 0 %h %h",
                     name, MEM_WR, MEM_RD, MEM_ADDR, MEM_WR_DATA, exp_byte_addr, exp_data);
        end
        tick();  // cycle 4
        checks++;
        if ({RSP_VALID, RSP_ERR, RSP_DATA, MEM_WR} !== {1'b1, 1'b0, exp_data, 1'b0}) begin
            errors++;
            $display("FAIL %s_c4_rsp: got rv=%b re=%b data=%h wr=%b expected 1 0 %h 0",
                     name, RSP_VALID, RSP_ERR, RSP_DATA, MEM_WR, exp_data);
        end
        tick();  // cycle 5
        checks++;
        if ({REQ_READY, RSP_VALID} !== 2'b10) begin
            errors++;
            $display("FAIL %s_c5_idle: got ready=%b rv=%b expected 1 0", name, REQ_READY, RSP_VALID);
        end
    endtask

    task automatic test_bit_write();
        // P1 holds 0xA5 from the byte write; set bit 3 -> 0xAD.
        run_bit_write("bit_set", 8'h93, 1'b1, 8'h90, 8'hAD);
        // Bit 7 already set: the write still happens with unchanged data.
        run_bit_write("bit_same", 8'h97, 1'b1, 8'h90, 8'hAD);
        // Load P0 = 0xFF, then clear bit 0 -> 0xFE.
        drive_req(2'b00, 8'h80, 8'hFF, 1'b0);
        tick();
        REQ_VALID = 1'b0;
        tick();
        tick();
        run_bit_write("bit_clr", 8'h80, 1'b0, 8'h80, 8'hFE);
    endtask

    // -----------------------------------------------------------------------
    task automatic run_error(input string name, input logic [1:0] op, input logic [7:0] addr);
        drive_req(op, addr, 8'h77, 1'b1);
        tick();  // cycle 1
        REQ_VALID = 1'b0;
        checks++;
        if ({RSP_VALID, RSP_ERR, RSP_DATA, MEM_WR, MEM_RD} !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s_c1: got rv=%b re=%b data=%h wr=%b rd=%b expected 1 1 00 0 0",
                     name, RSP_VALID, RSP_ERR, RSP_DATA, MEM_WR, MEM_RD);
        end
        tick();  // cycle 2
        checks++;
        if ({REQ_READY, RSP_VALID, RSP_ERR, MEM_WR, MEM_RD} !== 5'b10000) begin
            errors++;
            $display("FAIL %s_c2: got ready=%b rv=%b re=%b wr=%b rd=%b expected 1 0 0 0 0",
                     name, REQ_READY, RSP_VALID, RSP_ERR, MEM_WR, MEM_RD);
        end
    endtask

    task automatic test_errors();
        run_error("err_bit_ram", 2'b10, 8'h20);
        run_error("err_op11", 2'b11, 8'h90);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid();
        drive_req(2'b10, 8'hB7, 8'h00, 1'b1);
        tick();  // cycle 1: MEM_RD
        REQ_VALID = 1'b0;
        checks++;
        if ({MEM_RD, MEM_ADDR} !== {1'b1, 8'hB0}) begin
            errors++;
            $display("FAIL rst_mid_c1: got rd=%b addr=%h expected 1 b0", MEM_RD, MEM_ADDR);
        end
        tick();  // cycle 2
        RST = 1'b1;
        #1;
        checks++;
        if (REQ_READY !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ready: got %b expected 0", REQ_READY);
        end
        tick();  // reset applied
        checks++;
        if ({RSP_VALID, RSP_ERR, RSP_DATA, MEM_ADDR, MEM_WR_DATA, MEM_WR, MEM_RD} !== 29'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got rv=%b re=%b rd=%h ma=%h wd=%h wr=%b rdst=%b expected all 0",
                     RSP_VALID, RSP_ERR, RSP_DATA, MEM_ADDR, MEM_WR_DATA, MEM_WR, MEM_RD);
        end
        RST = 1'b0;
        #1;
        checks++;
        if (REQ_READY !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_ready_release: got %b expected 1", REQ_READY);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({MEM_WR, MEM_RD, RSP_VALID} !== 3'b000) begin
                errors++;
                $display("FAIL rst_mid_after_%0d: got wr=%b rd=%b rv=%b expected 0 0 0", i, MEM_WR, MEM_RD, RSP_VALID);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [6:0] exp_wr;
        logic [6:0] exp_ready;
        logic [6:0] exp_rv;
        exp_wr    = 7'b0010010;   // bit i = cycle i
        exp_ready = 7'b1001001;
        exp_rv    = 7'b0100100;
        drive_req(2'b00, 8'hA0, 8'h11, 1'b0);
        checks++;
        if (REQ_READY !== exp_ready[0]) begin
            errors++;
            $display("FAIL b2b_ready_c0: got %b expected %b", REQ_READY, exp_ready[0]);
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) drive_req(2'b00, 8'hB0, 8'h22, 1'b0);
            if (c == 4) REQ_VALID = 1'b0;
            checks++;
            if ({MEM_WR, REQ_READY, RSP_VALID, MEM_RD} !== {exp_wr[c], exp_ready[c], exp_rv[c], 1'b0}) begin
                errors++;
                $display("FAIL b2b_c%0d: got wr=%b ready=%b rv=%b rd=%b expected %b %b %b 0",
                         c, MEM_WR, REQ_READY, RSP_VALID, MEM_RD, exp_wr[c], exp_ready[c], exp_rv[c]);
            end
            if (c == 1) begin
                checks++;
                if ({MEM_ADDR, MEM_WR_DATA} !== {8'hA0, 8'h11}) begin
                    errors++;
                    $display("FAIL b2b_first_bus: got addr=%h data=%h expected a0 11", MEM_ADDR, MEM_WR_DATA);
                end
            end
            if (c == 4) begin
                checks++;
                if ({MEM_ADDR, MEM_WR_DATA} !== {8'hB0, 8'h22}) begin
                    errors++;
                    $display("FAIL b2b_second_bus: got addr=%h data=%h expected b0 22", MEM_ADDR, MEM_WR_DATA);
                end
            end
        end
        // Read both bytes back through the bridge.
        drive_req(2'b01, 8'hA0, 8'h00, 1'b0);
        tick();
        REQ_VALID = 1'b0;
        tick();
        tick();
        checks++;
        if ({RSP_VALID, RSP_DATA} !== {1'b1, 8'h11}) begin
            errors++;
            $display("FAIL b2b_readback_a0: got rv=%b data=%h expected 1 11", RSP_VALID, RSP_DATA);
        end
        tick();
        drive_req(2'b01, 8'hB0, 8'h00, 1'b0);
        tick();
        REQ_VALID = 1'b0;
        tick();
        tick();
        checks++;
        if ({RSP_VALID, RSP_DATA} !== {1'b1, 8'h22}) begin
            errors++;
            $display("FAIL b2b_readback_b0: got rv=%b data=%h expected 1 22", RSP_VALID, RSP_DATA);
        end
        tick();
    endtask

    // -----------------------------------------------------------------------
    initial begin
        checks      = 0;
        errors      = 0;
        RST         = 1'b1;
        REQ_VALID   = 1'b0;
        REQ_OP      = 2'b00;
        REQ_ADDR    = 8'h00;
        REQ_WDATA   = 8'h00;
        REQ_BIT_VAL = 1'b0;

        test_reset();
        test_byte_write();
        test_byte_read();
        test_bit_write();
        test_errors();
        test_reset_mid();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
